// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered sprite registers, fixed-priority hit test, sprite-memory
// fetch, and a transparency/background select. RGB and syncs share one 3-cycle pipeline.
module sprite_compositor #(
  parameter int          CHANNELS        = 4,
  parameter int          SPRITE_SIZE     = 32,
  parameter int          COLOR_BITS      = 3,
  parameter int          X_W             = 11,
  parameter int          Y_W             = 10,
  parameter logic [11:0] TRANSPARENT_KEY = 12'h000,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  localparam int         SEL_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int         LOG_S           = $clog2(SPRITE_SIZE),
  localparam int         AW              = 2 * LOG_S
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_enable,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [X_W-1:0]            pixel_x,
  input  logic [Y_W-1:0]            pixel_y,
  input  logic                      cfg_we,
  input  logic [SEL_W-1:0]          cfg_sel,
  input  logic [X_W-1:0]            cfg_x,
  input  logic [Y_W-1:0]            cfg_y,
  input  logic                      cfg_en,
  input  logic [3*COLOR_BITS-1:0]   bg_colour,
  output logic                      mem_en,
  output logic [SEL_W-1:0]          mem_element,
  output logic [AW-1:0]             mem_address,
  input  logic [11:0]               mem_data,
  output logic [COLOR_BITS-1:0]     vga_r,
  output logic [COLOR_BITS-1:0]     vga_g,
  output logic [COLOR_BITS-1:0]     vga_b,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      frame_commit
);

  localparam logic         SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [X_W:0] X_SPAN    = (X_W+1)'(SPRITE_SIZE);
  localparam logic [Y_W:0] Y_SPAN    = (Y_W+1)'(SPRITE_SIZE);

  logic [X_W-1:0]      sh_x [CHANNELS];
  logic [Y_W-1:0]      sh_y [CHANNELS];
  logic [CHANNELS-1:0] sh_en;
  logic [X_W-1:0]      ac_x [CHANNELS];
  logic [Y_W-1:0]      ac_y [CHANNELS];
  logic [CHANNELS-1:0] ac_en;

  logic vs_act, vs_q, commit;

  logic [CHANNELS-1:0] hit;
  logic                any_hit;
  logic [SEL_W-1:0]    winner;
  logic [X_W:0]        px_e;
  logic [Y_W:0]        py_e;
  logic [LOG_S-1:0]    dx, dy;

  logic ve0, hit0, hs0, vs0;
  logic ve1, hit1, hs1, vs1;
  logic [3*COLOR_BITS-1:0] rgb_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
      sh_en <= '0;
    end else if (cfg_we && (int'(cfg_sel) < CHANNELS)) begin
      sh_x[cfg_sel]  <= cfg_x;
      sh_y[cfg_sel]  <= cfg_y;
      sh_en[cfg_sel] <= cfg_en;
    end
  end

  // vs_q resets to "active" so a commit needs a real inactive->active transition after reset.
  assign vs_act = vsync_in ^ SYNC_ACTIVE_LOW;
  assign commit = vs_act & ~vs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q         <= 1'b1;
      frame_commit <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        ac_x[i] <= '0;
        ac_y[i] <= '0;
      end
      ac_en <= '0;
    end else begin
      vs_q         <= vs_act;
      frame_commit <= commit;
      if (commit) begin
        for (int i = 0; i < CHANNELS; i++) begin
          ac_x[i] <= sh_x[i];
          ac_y[i] <= sh_y[i];
        end
        ac_en <= sh_en;
      end
    end
  end

  // One extra bit on both sides keeps sprites near the right/bottom edge clipped rather than wrapped.
  assign px_e = {1'b0, pixel_x};
  assign py_e = {1'b0, pixel_y};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_hit
    logic [X_W:0] x_lo;
    logic [Y_W:0] y_lo;
    assign x_lo   = {1'b0, ac_x[g]};
    assign y_lo   = {1'b0, ac_y[g]};
    assign hit[g] = ac_en[g] && (px_e >= x_lo) && (px_e < x_lo + X_SPAN)
                             && (py_e >= y_lo) && (py_e < y_lo + Y_SPAN);
  end

  always_comb begin
    any_hit = 1'b0;
    winner  = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        winner  = SEL_W'(i);
      end
    end
  end

  assign dx = LOG_S'(pixel_x - ac_x[winner]);
  assign dy = LOG_S'(pixel_y - ac_y[winner]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en      <= 1'b0;
      mem_element <= '0;
      mem_address <= '0;
      ve0         <= 1'b0;
      hit0        <= 1'b0;
      hs0         <= SYNC_IDLE;
      vs0         <= SYNC_IDLE;
    end else begin
      mem_en <= video_enable & any_hit;
      if (any_hit) begin
        mem_element <= winner;
        mem_address <= {dy, dx};
      end
      ve0  <= video_enable;
      hit0 <= any_hit;
      hs0  <= hsync_in;
      vs0  <= vsync_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ve1  <= 1'b0;
      hit1 <= 1'b0;
      hs1  <= SYNC_IDLE;
      vs1  <= SYNC_IDLE;
    end else begin
      ve1  <= ve0;
      hit1 <= hit0;
      hs1  <= hs0;
      vs1  <= vs0;
    end
  end

  // A transparent winner shows background; lower-priority sprites are never fetched.
  always_comb begin
    rgb_nxt = '0;
    if (ve1) begin
      if (hit1 && (mem_data != TRANSPARENT_KEY))
        rgb_nxt = {mem_data[11 -: COLOR_BITS], mem_data[7 -: COLOR_BITS], mem_data[3 -: COLOR_BITS]};
      else
        rgb_nxt = bg_colour;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_nxt;
      hsync_out             <= hs1;
      vsync_out             <= vs1;
    end
  end

endmodule
